ring_checker: RTL and testbench

RING_CHECKER -- requirements
Module: ring_checker

---
 rtl/ring_checker.sv | 123 ++++++++++++
 tb/tb_ring_checker.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ring_checker.sv
// Watches a one-hot ring counter, locks onto a correctly rotating pattern and
// counts sequence errors once locked.
module ring_checker #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned DIR         = 0,
    parameter int unsigned LOCK_CNT    = 3,
    parameter int unsigned FAULT_LIMIT = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         ring_in,
    input  logic                     clr_err,
    output logic                     locked,
    output logic                     err_pulse,
    output logic [7:0]               err_count,
    output logic                     fault,
    output logic [$clog2(WIDTH)-1:0] position
);

    localparam int unsigned PW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        SEARCH,
        ACQUIRE,
        LOCKED
    } state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] prev, prev_nx, expected;
    logic [3:0]       cnt, cnt_nx, cnt_inc;
    logic             onehot, match, err_det;
    logic [7:0]       err_count_nx;
    logic             fault_nx;
    logic [PW-1:0]    idx, position_nx;

    always_comb begin
        if (DIR == 0) expected = {prev[WIDTH-2:0], prev[WIDTH-1]};
        else          expected = {prev[0], prev[WIDTH-1:1]};
    end

    assign onehot  = (ring_in != '0) && ((ring_in & (ring_in - WIDTH'(1))) == '0);
    assign match   = (ring_in == expected);
    assign cnt_inc = cnt + 4'd1;

    always_comb begin
        idx = '0;
        for (int unsigned i = 0; i < WIDTH; i++)
            if (ring_in[i]) idx = PW'(i);
    end

    always_comb begin
        state_nx = state;
        prev_nx  = prev;
        cnt_nx   = cnt;
        err_det  = 1'b0;
        case (state)
            SEARCH: begin
                if (onehot) begin
                    prev_nx  = ring_in;
                    cnt_nx   = '0;
                    state_nx = ACQUIRE;
                end
            end
            ACQUIRE: begin
                if (match) begin
                    prev_nx = ring_in;
                    cnt_nx  = cnt_inc;
                    if (cnt_inc == 4'(LOCK_CNT)) state_nx = LOCKED;
                end else if (onehot) begin
                    // A one-hot mismatch restarts acquisition straight away
                    prev_nx = ring_in;
                    cnt_nx  = '0;
                end else begin
                    cnt_nx   = '0;
                    state_nx = SEARCH;
                end
            end
            LOCKED: begin
                if (match) begin
                    prev_nx = ring_in;
                end else begin
                    err_det  = 1'b1;
                    cnt_nx   = '0;
                    state_nx = SEARCH;
                end
            end
            default: state_nx = SEARCH;
        endcase

        if (clr_err)
            err_count_nx = '0;
        else if (err_det && err_count != 8'hFF)
            err_count_nx = err_count + 8'd1;
        else
            err_count_nx = err_count;

        fault_nx    = clr_err ? 1'b0 : (fault | (err_count_nx >= 8'(FAULT_LIMIT)));
        position_nx = (state_nx == LOCKED) ? idx : '0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= SEARCH;
            prev      <= '0;
            cnt       <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            err_count <= '0;
            fault     <= 1'b0;
            position  <= '0;
        end else begin
            state     <= state_nx;
            prev      <= prev_nx;
            cnt       <= cnt_nx;
            locked    <= (state_nx == LOCKED);
            err_pulse <= err_det;
            err_count <= err_count_nx;
            fault     <= fault_nx;
            position  <= position_nx;
        end
    end

endmodule

// File: tb/tb_ring_checker.sv
// Bench for ring_checker: directed scenarios on a default instance plus random
// streams on two instances checked against a rotation-index reference model.
module tb_ring_checker;

    logic       clock;
    logic       reset;
    logic [7:0] ring_a;
    logic       clr_a;
    logic       locked_a, pulse_a, fault_a;
    logic [7:0] count_a;
    logic [2:0] pos_a;
    logic [4:0] ring_b;
    logic       clr_b;
    logic       locked_b, pulse_b, fault_b;
    logic [7:0] count_b;
    logic [2:0] pos_b;

    int n_vec = 0;
    int n_err = 0;

    ring_checker #(.WIDTH(8), .DIR(0), .LOCK_CNT(3), .FAULT_LIMIT(4)) dut_a (
        .clock(clock), .reset(reset), .ring_in(ring_a), .clr_err(clr_a),
        .locked(locked_a), .err_pulse(pulse_a), .err_count(count_a),
        .fault(fault_a), .position(pos_a)
    );

    ring_checker #(.WIDTH(5), .DIR(1), .LOCK_CNT(2), .FAULT_LIMIT(2)) dut_b (
        .clock(clock), .reset(reset), .ring_in(ring_b), .clr_err(clr_b),
        .locked(locked_b), .err_pulse(pulse_b), .err_count(count_b),
        .fault(fault_b), .position(pos_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        bit tracking;
        int pidx;
        int streak;
        int cnt;
        bit fault;
        bit pulse;
    } mstate_t;

    function automatic mstate_t mreset();
        mstate_t s;
        s.tracking = 0; s.pidx = 0; s.streak = 0; s.cnt = 0; s.fault = 0; s.pulse = 0;
        return s;
    endfunction

    // Model: tracks the index of the hot bit and a streak of correct steps.
    function automatic mstate_t mstep(mstate_t s, logic [31:0] v, bit clr,
                                      int w, int dir, int lc, int fl);
        int ones;
        int idx;
        int nxt;
        bit good;
        ones = $countones(v);
        idx = 0;
        for (int i = 0; i < w; i++) if (v[i]) idx = i;
        nxt = (dir == 0) ? (s.pidx + 1) % w : (s.pidx + w - 1) % w;
        good = (ones == 1) && (idx == nxt);
        s.pulse = 0;
        if (!s.tracking) begin
            if (ones == 1) begin s.tracking = 1; s.pidx = idx; s.streak = 0; end
        end else if (s.streak >= lc) begin
            if (good) s.pidx = idx;
            else begin
                s.pulse = 1;
                if (s.cnt < 255) s.cnt++;
                s.tracking = 0;
                s.streak = 0;
            end
        end else if (good) begin
            s.pidx = idx;
            s.streak++;
        end else if (ones == 1) begin
            s.pidx = idx;
            s.streak = 0;
        end else begin
            s.tracking = 0;
            s.streak = 0;
        end
        if (clr) begin s.cnt = 0; s.fault = 0; end
        else if (s.cnt >= fl) s.fault = 1;
        return s;
    endfunction

    function automatic logic [31:0] next_rot(logic [31:0] v, int w, int dir);
        int idx;
        logic [31:0] one;
        idx = 0;
        one = 32'd1;
        for (int i = 0; i < w; i++) if (v[i]) idx = i;
        idx = (dir == 0) ? (idx + 1) % w : (idx + w - 1) % w;
        return one << idx;
    endfunction

    task automatic drive_a(input logic [7:0] v, input logic clr);
        @(negedge clock);
        ring_a = v;
        clr_a  = clr;
        @(posedge clock);
        #1;
    endtask

    task automatic drive_b(input logic [4:0] v, input logic clr);
        @(negedge clock);
        ring_b = v;
        clr_b  = clr;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        ring_a = '0; clr_a = 1'b0;
        ring_b = '0; clr_b = 1'b0;
        @(posedge clock);
        #1;
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic lock_err(input logic [7:0] bad, input logic clr);
        drive_a(8'h01, 1'b0);
        drive_a(8'h02, 1'b0);
        drive_a(8'h04, 1'b0);
        drive_a(8'h08, 1'b0);
        drive_a(bad, clr);
    endtask

    task automatic test_reset();
        logic [7:0] pat [4];
        pat[0] = 8'h01; pat[1] = 8'h02; pat[2] = 8'h04; pat[3] = 8'h08;
        reset = 1'b0;
        ring_a = '0; clr_a = 1'b0; ring_b = '0; clr_b = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_a(pat[i], 1'b0);
            n_vec++;
            if ({locked_a, pulse_a, count_a, fault_a, pos_a} !== 14'd0) begin
                n_err++;
                $display("FAIL reset_hold[%0d] got lk=%b ep=%b ec=%0d f=%b pos=%0d want all 0",
                         i, locked_a, pulse_a, count_a, fault_a, pos_a);
            end
        end
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_lock();
        drive_a(8'h01, 1'b0);
        drive_a(8'h02, 1'b0);
        drive_a(8'h04, 1'b0);
        n_vec++;
        if (locked_a !== 1'b0) begin
            n_err++;
            $display("FAIL lock_early got locked=%b want 0", locked_a);
        end
        drive_a(8'h08, 1'b0);
        n_vec++;
        if ({locked_a, pos_a} !== {1'b1, 3'd3}) begin
            n_err++;
            $display("FAIL lock_at_08 got locked=%b pos=%0d want locked=1 pos=3", locked_a, pos_a);
        end
    endtask

    task automatic test_wrap();
        drive_a(8'h10, 1'b0);
        drive_a(8'h20, 1'b0);
        drive_a(8'h40, 1'b0);
        drive_a(8'h80, 1'b0);
        n_vec++;
        if ({locked_a, pulse_a, pos_a} !== {1'b1, 1'b0, 3'd7}) begin
            n_err++;
            $display("FAIL wrap_80 got lk=%b ep=%b pos=%0d want lk=1 ep=0 pos=7", locked_a, pulse_a, pos_a);
        end
        drive_a(8'h01, 1'b0);
        n_vec++;
        if ({locked_a, pulse_a, pos_a} !== {1'b1, 1'b0, 3'd0}) begin
            n_err++;
            $display("FAIL wrap_01 got lk=%b ep=%b pos=%0d want lk=1 ep=0 pos=0", locked_a, pulse_a, pos_a);
        end
    endtask

    task automatic test_error();
        drive_a(8'h02, 1'b0);
        drive_a(8'h04, 1'b0);
        drive_a(8'h08, 1'b0);
        drive_a(8'h05, 1'b0);
        n_vec++;
        if ({pulse_a, count_a, locked_a, pos_a} !== {1'b1, 8'd1, 1'b0, 3'd0}) begin
            n_err++;
            $display("FAIL err_detect got ep=%b ec=%0d lk=%b pos=%0d want ep=1 ec=1 lk=0 pos=0",
                     pulse_a, count_a, locked_a, pos_a);
        end
        drive_a(8'h00, 1'b0);
        n_vec++;
        if ({pulse_a, count_a, locked_a} !== {1'b0, 8'd1, 1'b0}) begin
            n_err++;
            $display("FAIL err_oneshot got ep=%b ec=%0d lk=%b want ep=0 ec=1 lk=0", pulse_a, count_a, locked_a);
        end
    endtask

    task automatic test_fault_clr();
        lock_err(8'h08, 1'b0);
        lock_err(8'h08, 1'b0);
        n_vec++;
        if ({count_a, fault_a} !== {8'd3, 1'b0}) begin
            n_err++;
            $display("FAIL fault_below got ec=%0d f=%b want ec=3 f=0", count_a, fault_a);
        end
        lock_err(8'h40, 1'b0);
        n_vec++;
        if ({count_a, fault_a, pulse_a} !== {8'd4, 1'b1, 1'b1}) begin
            n_err++;
            $display("FAIL fault_set got ec=%0d f=%b ep=%b want ec=4 f=1 ep=1", count_a, fault_a, pulse_a);
        end
        drive_a(8'h00, 1'b0);
        n_vec++;
        if (fault_a !== 1'b1) begin
            n_err++;
            $display("FAIL fault_sticky got f=%b want 1", fault_a);
        end
        lock_err(8'h03, 1'b1);
        n_vec++;
        if ({count_a, fault_a, pulse_a} !== {8'd0, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL clr_wins got ec=%0d f=%b ep=%b want ec=0 f=0 ep=1", count_a, fault_a, pulse_a);
        end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 260; i++) lock_err(8'h00, 1'b0);
        n_vec++;
        if ({count_a, fault_a} !== {8'd255, 1'b1}) begin
            n_err++;
            $display("FAIL saturate got ec=%0d f=%b want ec=255 f=1", count_a, fault_a);
        end
        drive_a(8'h00, 1'b1);
        n_vec++;
        if ({count_a, fault_a} !== {8'd0, 1'b0}) begin
            n_err++;
            $display("FAIL clr_alone got ec=%0d f=%b want ec=0 f=0", count_a, fault_a);
        end
    endtask

    task automatic test_reset_midlock();
        drive_a(8'h01, 1'b0);
        drive_a(8'h02, 1'b0);
        drive_a(8'h04, 1'b0);
        drive_a(8'h08, 1'b0);
        drive_a(8'h10, 1'b0);
        drive_a(8'h20, 1'b0);
        n_vec++;
        if ({locked_a, pos_a} !== {1'b1, 3'd5}) begin
            n_err++;
            $display("FAIL pre_reset got lk=%b pos=%0d want lk=1 pos=5", locked_a, pos_a);
        end
        #2 reset = 1'b0;
        #1;
        n_vec++;
        if ({locked_a, pulse_a, count_a, fault_a, pos_a} !== 14'd0) begin
            n_err++;
            $display("FAIL async_reset got lk=%b ep=%b ec=%0d f=%b pos=%0d want all 0",
                     locked_a, pulse_a, count_a, fault_a, pos_a);
        end
        #2 reset = 1'b1;
        // The held 20 is sampled first and only anchors acquisition.
        drive_a(8'h40, 1'b0);
        drive_a(8'h80, 1'b0);
        n_vec++;
        if (locked_a !== 1'b0) begin
            n_err++;
            $display("FAIL reacq_early got lk=%b want 0", locked_a);
        end
        drive_a(8'h01, 1'b0);
        drive_a(8'h02, 1'b0);
        n_vec++;
        if ({locked_a, pos_a} !== {1'b1, 3'd1}) begin
            n_err++;
            $display("FAIL reacq_lock got lk=%b pos=%0d want lk=1 pos=1", locked_a, pos_a);
        end
    endtask

    task automatic test_random_a();
        mstate_t s;
        logic [31:0] v;
        logic [31:0] one;
        bit clr;
        int r;
        bit lk_e;
        int pos_e;
        one = 32'd1;
        do_reset();
        s = mreset();
        v = '0;
        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(0, 99);
            if (r < 75 && $countones(v) == 1) v = next_rot(v, 8, 0);
            else if (r < 88) v = one << $urandom_range(0, 7);
            else if (r < 94) v = v;
            else v = {24'd0, 8'($urandom)};
            clr = ($urandom_range(0, 39) == 0);
            drive_a(v[7:0], clr);
            s = mstep(s, v, clr, 8, 0, 3, 4);
            lk_e = s.tracking && (s.streak >= 3);
            pos_e = lk_e ? s.pidx : 0;
            n_vec++;
            if ({locked_a, pulse_a, count_a, fault_a, pos_a} !==
                {lk_e, s.pulse, 8'(s.cnt), s.fault, 3'(pos_e)}) begin
                n_err++;
                $display("FAIL rand_a[%0d] in=%h got lk=%b ep=%b ec=%0d f=%b pos=%0d want lk=%b ep=%b ec=%0d f=%b pos=%0d",
                         n, v[7:0], locked_a, pulse_a, count_a, fault_a, pos_a,
                         lk_e, s.pulse, s.cnt, s.fault, pos_e);
            end
        end
    endtask

    task automatic test_random_dir1();
        mstate_t s;
        logic [31:0] v;
        logic [31:0] one;
        bit clr;
        int r;
        bit lk_e;
        int pos_e;
        one = 32'd1;
        do_reset();
        s = mreset();
        v = '0;
        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(0, 99);
            if (r < 75 && $countones(v) == 1) v = next_rot(v, 5, 1);
            else if (r < 88) v = one << $urandom_range(0, 4);
            else if (r < 94) v = v;
            else v = {27'd0, 5'($urandom)};
            clr = ($urandom_range(0, 39) == 0);
            drive_b(v[4:0], clr);
            s = mstep(s, v, clr, 5, 1, 2, 2);
            lk_e = s.tracking && (s.streak >= 2);
            pos_e = lk_e ? s.pidx : 0;
            n_vec++;
            if ({locked_b, pulse_b, count_b, fault_b, pos_b} !==
                {lk_e, s.pulse, 8'(s.cnt), s.fault, 3'(pos_e)}) begin
                n_err++;
                $display("FAIL rand_dir1[%0d] in=%h got lk=%b ep=%b ec=%0d f=%b pos=%0d want lk=%b ep=%b ec=%0d f=%b pos=%0d",
                         n, v[4:0], locked_b, pulse_b, count_b, fault_b, pos_b,
                         lk_e, s.pulse, s.cnt, s.fault, pos_e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_wrap();
        test_error();
        test_fault_clr();
        test_saturate();
        test_reset_midlock();
        test_random_a();
        test_random_dir1();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
